// File: rtl/tcore_mtimer.sv
`default_nettype none
// ============================================================================
// Module   : tcore_mtimer
// Brief    : Machine timer responder: 64-bit mtime with prescaler, 64-bit
//            mtimecmp, coherent high-word snapshot and level interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module tcore_mtimer #(
    parameter int          XLEN    = 32,
    parameter logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stb_i,
    input  logic [2:0]      adr_i,
    input  logic [3:0]      byte_sel_i,
    input  logic            we_i,
    input  logic [XLEN-1:0] dat_i,
    output logic [XLEN-1:0] dat_o,
    output logic            irq_o
);

    localparam logic [2:0] c_ADR_TIME_LO = 3'd0;
    localparam logic [2:0] c_ADR_TIME_HI = 3'd1;
    localparam logic [2:0] c_ADR_CMP_LO  = 3'd2;
    localparam logic [2:0] c_ADR_CMP_HI  = 3'd3;
    localparam logic [2:0] c_ADR_CTRL    = 3'd4;
    localparam logic [2:0] c_ADR_STATUS  = 3'd5;

    logic [63:0] mtime_q,   mtime_d;
    logic [63:0] cmp_q,     cmp_d;
    logic [31:0] hi_snap_q, hi_snap_d;
    logic [15:0] pcnt_q,    pcnt_d;
    logic [15:0] presc_q,   presc_d;
    logic        en_q,      en_d;
    logic        ie_q,      ie_d;
    logic        irq_q,     irq_d;

    logic        w_wr;
    logic        w_rd;
    logic        w_tick;
    logic        w_pend;
    logic [31:0] w_ctrl_word;

    function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = sel[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return r;
    endfunction

    always_comb begin
        w_wr        = stb_i & we_i;
        w_rd        = stb_i & ~we_i;
        w_pend      = (mtime_q >= cmp_q);
        w_ctrl_word = {en_q, ie_q, 14'd0, presc_q};
    end

    // A CTRL write restarts the prescale period and suppresses that cycle's tick.
    always_comb begin
        pcnt_d = pcnt_q;
        w_tick = 1'b0;
        if (w_wr && (adr_i == c_ADR_CTRL)) begin
            pcnt_d = 16'd0;
        end else if (en_q) begin
            if (pcnt_q == presc_q) begin
                pcnt_d = 16'd0;
                w_tick = 1'b1;
            end else begin
                pcnt_d = pcnt_q + 16'd1;
            end
        end
    end

    // A bus write to either mtime half overrides (and drops) a coincident tick.
    always_comb begin
        mtime_d = w_tick ? (mtime_q + 64'd1) : mtime_q;
        cmp_d   = cmp_q;
        en_d    = en_q;
        ie_d    = ie_q;
        presc_d = presc_q;
        if (w_wr) begin
            case (adr_i)
                c_ADR_TIME_LO: mtime_d = {mtime_q[63:32], lane_merge(mtime_q[31:0], dat_i, byte_sel_i)};
                c_ADR_TIME_HI: mtime_d = {lane_merge(mtime_q[63:32], dat_i, byte_sel_i), mtime_q[31:0]};
                c_ADR_CMP_LO:  cmp_d   = {cmp_q[63:32], lane_merge(cmp_q[31:0], dat_i, byte_sel_i)};
                c_ADR_CMP_HI:  cmp_d   = {lane_merge(cmp_q[63:32], dat_i, byte_sel_i), cmp_q[31:0]};
                c_ADR_CTRL: begin
                    en_d    = byte_sel_i[3] ? dat_i[31] : en_q;
                    ie_d    = byte_sel_i[3] ? dat_i[30] : ie_q;
                    presc_d = {byte_sel_i[1] ? dat_i[15:8] : presc_q[15:8],
                               byte_sel_i[0] ? dat_i[7:0]  : presc_q[7:0]};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        hi_snap_d = (w_rd && (adr_i == c_ADR_TIME_LO)) ? mtime_q[63:32] : hi_snap_q;
        irq_d     = ie_q & w_pend;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mtime_q   <= 64'd0;
            cmp_q     <= CMP_RST;
            hi_snap_q <= 32'd0;
            pcnt_q    <= 16'd0;
            presc_q   <= 16'd0;
            en_q      <= 1'b0;
            ie_q      <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            mtime_q   <= mtime_d;
            cmp_q     <= cmp_d;
            hi_snap_q <= hi_snap_d;
            pcnt_q    <= pcnt_d;
            presc_q   <= presc_d;
            en_q      <= en_d;
            ie_q      <= ie_d;
            irq_q     <= irq_d;
        end
    end

    // Read data is combinational: the memory stage samples it in the access cycle.
    always_comb begin
        dat_o = '0;
        if (w_rd) begin
            case (adr_i)
                c_ADR_TIME_LO: dat_o = mtime_q[31:0];
                c_ADR_TIME_HI: dat_o = hi_snap_q;
                c_ADR_CMP_LO:  dat_o = cmp_q[31:0];
                c_ADR_CMP_HI:  dat_o = cmp_q[63:32];
                c_ADR_CTRL:    dat_o = w_ctrl_word;
                c_ADR_STATUS:  dat_o = {30'd0, irq_q, w_pend};
                default:       dat_o = '0;
            endcase
        end
    end

    assign irq_o = irq_q;

endmodule
`default_nettype wire
